// File: rtl/draw_pkg.sv
// rtl/draw_pkg.sv - shared state encoding and AXI constants for the fill engine
//
// Purpose: types and constants shared by draw_fill and draw_burstcalc.
// Ports: none (package).
package draw_pkg;

  typedef enum logic [2:0] {
    IDLE,
    AW,
    W,
    B,
    FIN
  } draw_state_e;

  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_CACHE      = 4'b0011;

  localparam int MAX_BURST = 32;

endpackage

// File: rtl/draw_burstcalc.sv
// rtl/draw_burstcalc.sv - combinational burst sizing for 8-byte-beat INCR bursts
//
// Purpose: picks the next burst length so that it never exceeds the beats left
// in the line, MAX_BEATS, or the distance to the next 4 KB boundary.
// Ports:
//   addr_beat   - address bits [11:3], beat index inside the current 4 KB page
//   beats_rem   - beats still to write in the current line (non-zero)
//   burst_beats - beats in the chosen burst (1..MAX_BEATS)
//   burst_len   - same value in AWLEN encoding (beats - 1)
//   beats_after - beats left in the line once this burst is done
module draw_burstcalc
  import draw_pkg::*;
#(
  parameter int MAX_BEATS = MAX_BURST
) (
  input  logic [8:0]  addr_beat,
  input  logic [11:0] beats_rem,
  output logic [11:0] burst_beats,
  output logic [7:0]  burst_len,
  output logic [11:0] beats_after
);

  localparam logic [11:0] MAX_B = 12'(MAX_BEATS);

  logic [11:0] room;

  always_comb begin
    // 512 beats per 4 KB page; room is always at least 1 for an aligned address
    room        = 12'd512 - {3'd0, addr_beat};
    burst_beats = beats_rem;
    if (burst_beats > MAX_B) burst_beats = MAX_B;
    if (burst_beats > room)  burst_beats = room;
    burst_len   = 8'(burst_beats - 12'd1);
    beats_after = beats_rem - burst_beats;
  end

endmodule

// File: rtl/draw_fill.sv
// rtl/draw_fill.sv - solid-colour rectangle fill engine on the AXI write channels
//
// Purpose: writes FILL_H lines of FILL_W 32-bit pixels of COLOR starting at
// DSTADDR with line pitch STRIDE, one INCR burst outstanding at a time.
// Ports:
//   ACLK, ARESETN            - clock, asynchronous active-low reset
//   START, DSTADDR, STRIDE,
//   FILL_W, FILL_H, COLOR    - fill request, latched when idle
//   BUSY, DONE, ERR          - status (ERR sticky until next accepted START)
//   M_AXI_AW*, M_AXI_W*,
//   M_AXI_B*                 - AXI write address, data and response channels
module draw_fill
  import draw_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 64,
  parameter int MAX_BURST          = draw_pkg::MAX_BURST
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic                              START,
  input  logic [31:0]                       DSTADDR,
  input  logic [15:0]                       STRIDE,
  input  logic [11:0]                       FILL_W,
  input  logic [11:0]                       FILL_H,
  input  logic [31:0]                       COLOR,
  output logic                              BUSY,
  output logic                              DONE,
  output logic                              ERR,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [7:0]                        M_AXI_AWLEN,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [2:0]                        M_AXI_AWSIZE,
  output logic [1:0]                        M_AXI_AWBURST,
  output logic [3:0]                        M_AXI_AWCACHE,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WLAST,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY
);

  draw_state_e state, state_nxt;

  logic [31:0] line_base, nxt_addr, color_q;
  logic [15:0] stride_q;
  logic [11:0] bpl_q, beats_rem, lines_rem;
  logic        odd_q, ends_line, err_q;
  logic [7:0]  beat_cnt;

  logic [31:0] dst_al, calc_addr;
  logic [11:0] bpl_in, calc_beats, bc_beats, bc_after;
  logic [7:0]  bc_len;
  logic        start_acc, zero_fill, b_hs, w_hs, w_last;
  logic        line_end, last_line, fill_end, issue, line_adv;

  assign dst_al    = DSTADDR & 32'hFFFF_FFF8;
  assign bpl_in    = {1'b0, FILL_W[11:1]} + {11'd0, FILL_W[0]};
  assign start_acc = (state == IDLE) && START;
  assign zero_fill = (FILL_W == 12'd0) || (FILL_H == 12'd0);
  assign b_hs      = (state == B) && M_AXI_BVALID;
  assign w_hs      = (state == W) && M_AXI_WREADY;
  assign w_last    = (beat_cnt == M_AXI_AWLEN);
  assign line_end  = (beats_rem == 12'd0);
  assign last_line = (lines_rem == 12'd1);
  assign fill_end  = line_end && last_line;
  // A burst is sized and registered in the same cycle the previous step
  // completes, so AWADDR/AWLEN are already valid when AWVALID rises.
  assign issue     = (start_acc && !zero_fill) || (b_hs && !fill_end);
  assign line_adv  = b_hs && line_end && !last_line;

  always_comb begin
    calc_addr  = nxt_addr;
    calc_beats = beats_rem;
    if (state == IDLE) begin
      calc_addr  = dst_al;
      calc_beats = bpl_in;
    end else if (line_end) begin
      calc_addr  = line_base + {16'd0, stride_q};
      calc_beats = bpl_q;
    end
  end

  draw_burstcalc #(.MAX_BEATS(MAX_BURST)) u_burstcalc (
    .addr_beat   (calc_addr[11:3]),
    .beats_rem   (calc_beats),
    .burst_beats (bc_beats),
    .burst_len   (bc_len),
    .beats_after (bc_after)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state        <= IDLE;
      line_base    <= '0;
      nxt_addr     <= '0;
      color_q      <= '0;
      stride_q     <= '0;
      bpl_q        <= '0;
      beats_rem    <= '0;
      lines_rem    <= '0;
      odd_q        <= 1'b0;
      ends_line    <= 1'b0;
      err_q        <= 1'b0;
      beat_cnt     <= '0;
      M_AXI_AWADDR <= '0;
      M_AXI_AWLEN  <= '0;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        line_base <= dst_al;
        color_q   <= COLOR;
        stride_q  <= STRIDE & 16'hFFF8;
        bpl_q     <= bpl_in;
        odd_q     <= FILL_W[0];
        lines_rem <= FILL_H;
        err_q     <= 1'b0;
      end
      if (b_hs && (M_AXI_BRESP != 2'b00)) err_q <= 1'b1;
      if (line_adv) begin
        line_base <= calc_addr;
        lines_rem <= lines_rem - 12'd1;
      end
      if (issue) begin
        M_AXI_AWADDR <= calc_addr;
        M_AXI_AWLEN  <= bc_len;
        nxt_addr     <= calc_addr + {17'd0, bc_beats, 3'd0};
        beats_rem    <= bc_after;
        ends_line    <= (bc_after == 12'd0);
        beat_cnt     <= '0;
      end else if (w_hs) begin
        beat_cnt <= beat_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_WLAST   = 1'b0;
    M_AXI_WSTRB   = 8'h00;
    M_AXI_BREADY  = 1'b0;
    DONE          = 1'b0;
    BUSY          = (state != IDLE);
    case (state)
      IDLE: if (START) state_nxt = zero_fill ? FIN : AW;
      AW: begin
        M_AXI_AWVALID = 1'b1;
        if (M_AXI_AWREADY) state_nxt = W;
      end
      W: begin
        M_AXI_WVALID = 1'b1;
        M_AXI_WLAST  = w_last;
        // Only the line's final beat of an odd-width line is half-used
        M_AXI_WSTRB  = (w_last && ends_line && odd_q) ? 8'h0F : 8'hFF;
        if (M_AXI_WREADY && w_last) state_nxt = B;
      end
      B: begin
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID) state_nxt = fill_end ? FIN : AW;
      end
      FIN: begin
        DONE      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ERR           = err_q;
  assign M_AXI_WDATA   = {color_q, color_q};
  assign M_AXI_AWSIZE  = AXI_SIZE_8B;
  assign M_AXI_AWBURST = AXI_BURST_INCR;
  assign M_AXI_AWCACHE = AXI_CACHE;

endmodule

// File: tb/tb_draw_fill.sv
// tb/tb_draw_fill.sv - self-checking bench for draw_fill
//
// Purpose: table of fill requests with modelled burst/beat queues and memory
// image, checked by an AXI slave model; plus reset-state and reset-mid-burst
// sequences.
// Ports: none (top-level bench).
module tb_draw_fill;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        START = 1'b0;
  logic [31:0] DSTADDR = '0;
  logic [15:0] STRIDE = '0;
  logic [11:0] FILL_W = '0, FILL_H = '0;
  logic [31:0] COLOR = '0;
  logic        BUSY, DONE, ERR;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic        AWVALID, AWREADY = 1'b0;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic [3:0]  AWCACHE;
  logic [63:0] WDATA;
  logic [7:0]  WSTRB;
  logic        WLAST, WVALID, WREADY = 1'b0;
  logic [1:0]  BRESP = 2'b00;
  logic        BVALID = 1'b0, BREADY;

  always #5 ACLK = ~ACLK;

  draw_fill dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .START(START), .DSTADDR(DSTADDR),
    .STRIDE(STRIDE), .FILL_W(FILL_W), .FILL_H(FILL_H), .COLOR(COLOR),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .M_AXI_AWADDR(AWADDR), .M_AXI_AWLEN(AWLEN), .M_AXI_AWVALID(AWVALID),
    .M_AXI_AWREADY(AWREADY), .M_AXI_AWSIZE(AWSIZE), .M_AXI_AWBURST(AWBURST),
    .M_AXI_AWCACHE(AWCACHE), .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB),
    .M_AXI_WLAST(WLAST), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
    .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY)
  );

  typedef struct {
    logic [31:0] dst;
    logic [15:0] stride;
    logic [11:0] w;
    logic [11:0] h;
    logic [31:0] color;
    logic        rnd;
    int          bad;
    int          nb;
    logic [31:0] a0;
    logic [7:0]  l0;
    logic [31:0] a1;
    logic [7:0]  l1;
    logic        err;
  } vec_t;
  typedef struct { logic [31:0] addr; logic [7:0] len; } aw_t;
  typedef struct { logic [7:0] strb; logic last; } wb_t;

  vec_t vecs[9];
  aw_t  exp_aw[$];
  wb_t  exp_w[$];
  logic [7:0] mem  [logic [31:0]];
  logic [7:0] emem [logic [31:0]];

  int n_cmp = 0, n_bad = 0, cur_vec = -1;
  int aw_cnt = 0, wlast_cnt = 0, pend = 0, resp_idx = 0, bad_idx = -1;
  logic        rnd_mode = 1'b0, b_hs_q = 1'b0;
  logic [31:0] cur_color = '0, w_addr = '0;
  logic [31:0] act_a[2];
  logic [7:0]  act_l[2];
  logic        p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr = 1'b0, p_wlast = 1'b0;
  logic [31:0] p_awaddr = '0;
  logic [7:0]  p_awlen = '0, p_wstrb = '0;
  logic [63:0] p_wdata = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (vec %0d): actual %0h required %0h", name, cur_vec, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (vec %0d): actual event state differs from required", name, cur_vec);
  endtask

  // Expected bursts, beats and bytes for one fill request.
  task automatic model(input vec_t v);
    logic [31:0] base, a;
    logic [7:0]  strb;
    int rem, len, room;
    base = v.dst & 32'hFFFF_FFF8;
    if (v.w == 12'd0 || v.h == 12'd0) return;
    for (int ln = 0; ln < int'(v.h); ln++) begin
      a   = base;
      rem = (int'(v.w) + 1) / 2;
      while (rem > 0) begin
        room = (4096 - int'(a[11:0])) / 8;
        len  = rem;
        if (len > 32)   len = 32;
        if (len > room) len = room;
        exp_aw.push_back('{a, 8'(len - 1)});
        for (int i = 0; i < len; i++) begin
          strb = ((rem - i == 1) && v.w[0]) ? 8'h0F : 8'hFF;
          exp_w.push_back('{strb, (i == len - 1)});
          for (int k = 0; k < 8; k++)
            if (strb[k]) emem[a + 32'(8 * i + k)] = v.color[8 * (k % 4) +: 8];
        end
        a   = a + 32'(8 * len);
        rem = rem - len;
      end
      base = base + {16'd0, v.stride & 16'hFFF8};
    end
  endtask

  // AXI slave: drives readies/responses and checks traffic against the queues.
  always @(negedge ACLK) begin
    aw_t e_aw;
    wb_t e_w;
    if (!ARESETN) begin
      AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
      pend = 0; b_hs_q = 1'b0; p_awv = 1'b0; p_wv = 1'b0;
    end else begin
      if (b_hs_q) begin
        BVALID = 1'b0;
        pend--;
        resp_idx++;
      end
      if (p_awv && !p_awr) begin
        chk("awvalid_hold", 64'(AWVALID), 64'(1));
        chk("awaddr_stable", 64'(AWADDR), 64'(p_awaddr));
        chk("awlen_stable", 64'(AWLEN), 64'(p_awlen));
      end
      if (p_wv && !p_wr) begin
        chk("wvalid_hold", 64'(WVALID), 64'(1));
        chk("wstrb_stable", 64'(WSTRB), 64'(p_wstrb));
        chk("wlast_stable", 64'(WLAST), 64'(p_wlast));
        chk("wdata_stable", WDATA, p_wdata);
      end
      AWREADY = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      WREADY  = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!BVALID && pend > 0 && (!rnd_mode || $urandom_range(0, 1) == 1)) begin
        BVALID = 1'b1;
        BRESP  = (resp_idx == bad_idx) ? 2'b10 : 2'b00;
      end
      if (AWVALID && AWREADY) begin
        if (exp_aw.size() == 0) fail_evt("aw_unexpected");
        else begin
          e_aw = exp_aw.pop_front();
          chk("awaddr", 64'(AWADDR), 64'(e_aw.addr));
          chk("awlen", 64'(AWLEN), 64'(e_aw.len));
        end
        if (aw_cnt < 2) begin
          act_a[aw_cnt] = AWADDR;
          act_l[aw_cnt] = AWLEN;
        end
        aw_cnt++;
        w_addr = AWADDR;
      end
      if (WVALID) chk("w_after_aw", 64'(aw_cnt > wlast_cnt), 64'(1));
      if (WVALID && WREADY) begin
        if (exp_w.size() == 0) fail_evt("w_unexpected");
        else begin
          e_w = exp_w.pop_front();
          chk("wstrb", 64'(WSTRB), 64'(e_w.strb));
          chk("wlast", 64'(WLAST), 64'(e_w.last));
          chk("wdata", WDATA, {cur_color, cur_color});
        end
        for (int k = 0; k < 8; k++)
          if (WSTRB[k]) mem[w_addr + 32'(k)] = WDATA[8 * k +: 8];
        w_addr = w_addr + 32'd8;
        if (WLAST) begin
          wlast_cnt++;
          pend++;
        end
      end
      b_hs_q   = BVALID && BREADY;
      p_awv    = AWVALID; p_awr = AWREADY; p_awaddr = AWADDR; p_awlen = AWLEN;
      p_wv     = WVALID;  p_wr  = WREADY;  p_wstrb  = WSTRB;  p_wlast = WLAST;
      p_wdata  = WDATA;
    end
  end

  task automatic start_vec(input vec_t v, input int idx);
    cur_vec = idx;
    exp_aw.delete(); exp_w.delete(); mem.delete(); emem.delete();
    aw_cnt = 0; wlast_cnt = 0; resp_idx = 0;
    bad_idx = v.bad; rnd_mode = v.rnd; cur_color = v.color;
    act_a[0] = '0; act_a[1] = '0; act_l[0] = '0; act_l[1] = '0;
    model(v);
    @(negedge ACLK);
    DSTADDR = v.dst; STRIDE = v.stride; FILL_W = v.w; FILL_H = v.h;
    COLOR = v.color; START = 1'b1;
    @(negedge ACLK);
    START = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int dn, after, nbytes;
    start_vec(v, idx);
    chk("busy_after_start", 64'(BUSY), 64'(1));
    chk("err_cleared_by_start", 64'(ERR), 64'(0));
    chk("awvalid_after_start", 64'(AWVALID), 64'(v.nb != 0));
    chk("done_after_start", 64'(DONE), 64'(v.nb == 0));
    dn = 0;
    after = -1;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (DONE) dn++;
      if (cyc == 2 && v.nb != 0) begin
        // request while busy must be ignored
        START = 1'b1; FILL_W = 12'd9; FILL_H = 12'd9; DSTADDR = 32'h5555_0000;
      end else begin
        START = 1'b0;
      end
      if (dn > 0) begin
        after++;
        if (after == 6) break;
      end
      @(negedge ACLK);
    end
    START = 1'b0;
    if (after < 6) fail_evt("done_timeout");
    chk("done_pulses", 64'(dn), 64'(1));
    chk("err_final", 64'(ERR), 64'(v.err));
    chk("busy_idle", 64'(BUSY), 64'(0));
    chk("aw_count", 64'(aw_cnt), 64'(v.nb));
    chk("wlast_count", 64'(wlast_cnt), 64'(v.nb));
    chk("aw_left", 64'(exp_aw.size()), 64'(0));
    chk("w_left", 64'(exp_w.size()), 64'(0));
    if (v.nb >= 1) begin
      chk("aw0_addr", 64'(act_a[0]), 64'(v.a0));
      chk("aw0_len", 64'(act_l[0]), 64'(v.l0));
    end
    if (v.nb >= 2) begin
      chk("aw1_addr", 64'(act_a[1]), 64'(v.a1));
      chk("aw1_len", 64'(act_l[1]), 64'(v.l1));
    end
    nbytes = 0;
    foreach (emem[a]) if (!mem.exists(a) || mem[a] !== emem[a]) nbytes++;
    chk("image_bad_bytes", 64'(nbytes), 64'(0));
    chk("image_size", 64'(mem.num()), 64'(emem.num()));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 64'(BUSY), 64'(0));
    chk({tag, "_done"}, 64'(DONE), 64'(0));
    chk({tag, "_err"}, 64'(ERR), 64'(0));
    chk({tag, "_awvalid"}, 64'(AWVALID), 64'(0));
    chk({tag, "_wvalid"}, 64'(WVALID), 64'(0));
    chk({tag, "_wlast"}, 64'(WLAST), 64'(0));
    chk({tag, "_bready"}, 64'(BREADY), 64'(0));
    chk({tag, "_awaddr"}, 64'(AWADDR), 64'(0));
    chk({tag, "_awlen"}, 64'(AWLEN), 64'(0));
    chk({tag, "_wstrb"}, 64'(WSTRB), 64'(0));
  endtask

  initial begin
    //          dst           stride    w       h      color         rnd  bad nb  a0            l0    a1            l1    err
    vecs[0] = '{32'h1000_0000, 16'h0000, 12'd64, 12'd1, 32'h00AA_BBCC, 1'b0, -1, 1, 32'h1000_0000, 8'd31, 32'h0,         8'd0,  1'b0};
    vecs[1] = '{32'h0000_0100, 16'h1400, 12'd5,  12'd2, 32'h0011_2233, 1'b0, -1, 2, 32'h0000_0100, 8'd2,  32'h0000_1500, 8'd2,  1'b0};
    vecs[2] = '{32'h0000_0FC0, 16'h0000, 12'd64, 12'd1, 32'h0044_5566, 1'b0, -1, 2, 32'h0000_0FC0, 8'd7,  32'h0000_1000, 8'd23, 1'b0};
    vecs[3] = '{32'h0000_2000, 16'h0040, 12'd4,  12'd3, 32'h0077_8899, 1'b1,  1, 3, 32'h0000_2000, 8'd1,  32'h0000_2040, 8'd1,  1'b1};
    vecs[4] = '{32'h0000_3000, 16'h0040, 12'd4,  12'd1, 32'h00DE_AD01, 1'b0, -1, 1, 32'h0000_3000, 8'd1,  32'h0,         8'd0,  1'b0};
    vecs[5] = '{32'h0000_0F05, 16'h0207, 12'd77, 12'd5, 32'h0012_34EF, 1'b1, -1, 10, 32'h0000_0F00, 8'd31, 32'h0000_1000, 8'd6,  1'b0};
    vecs[6] = '{32'hFFFF_FFC0, 16'h0040, 12'd32, 12'd2, 32'h00C0_FFEE, 1'b0, -1, 3, 32'hFFFF_FFC0, 8'd7,  32'h0000_0000, 8'd7,  1'b0};
    vecs[7] = '{32'h0000_4000, 16'h0040, 12'd10, 12'd0, 32'h0000_0001, 1'b0, -1, 0, 32'h0,         8'd0,  32'h0,         8'd0,  1'b0};
    vecs[8] = '{32'h0000_4000, 16'h0040, 12'd0,  12'd2, 32'h0000_0002, 1'b0, -1, 0, 32'h0,         8'd0,  32'h0,         8'd0,  1'b0};

    repeat (2) @(negedge ACLK);
    chk_reset_outputs("por");
    ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // reset asserted between clock edges while write data is in flight
    start_vec(vecs[0], 100);
    for (int cyc = 0; cyc < 50 && !WVALID; cyc++) @(negedge ACLK);
    chk("rst_reached_w", 64'(WVALID), 64'(1));
    #2;
    ARESETN = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    run_vec(vecs[1], 101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
